// File: rtl/fetch_prefetch_queue.sv
// Fetch PC owner plus DEPTH-entry prefetch queue; head valid one cycle after enqueue.
// Backpressure: enqueue stalls while full unless the head leaves; a flush empties the queue.
module fetch_prefetch_queue #(
  parameter int                WIDTH    = 32,
  parameter int                DEPTH    = 4,
  parameter int                IM_AW    = 12,
  parameter logic [WIDTH-1:0]  RESET_PC = 32'h0000_3000,
  parameter logic [WIDTH-1:0]  EXC_PC   = 32'h0000_4180
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [WIDTH-1:0]         redirect_pc,
  input  logic                     exc_req,
  output logic [IM_AW-1:0]         im_addr,
  input  logic [WIDTH-1:0]         im_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         instr_out,
  output logic [WIDTH-1:0]         pc_out,
  output logic [WIDTH-1:0]         pcadd4_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] redirect_tgt;
  logic             flush;
  logic             full;
  logic             deq;
  logic             enq;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign count        = wptr - rptr;
  assign full         = (count == (PW+1)'(DEPTH));
  assign out_valid    = (count != '0);
  assign deq          = out_valid & out_ready;
  assign flush        = exc_req | redirect_valid;
  assign enq          = ~flush & (~full | deq);
  assign redirect_tgt = redirect_pc & ~(WIDTH'(3));

  assign im_addr      = fetch_pc[IM_AW+1:2];

  assign head         = mem[rptr[PW-1:0]];
  assign instr_out    = out_valid ? head.instr : '0;
  assign pc_out       = out_valid ? head.pc : '0;
  assign pcadd4_out   = out_valid ? (head.pc + WIDTH'(4)) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      wptr     <= '0;
      rptr     <= '0;
    end else if (flush) begin
      // A same-cycle dequeue still completes at decode; the queue is simply dropped.
      fetch_pc <= exc_req ? EXC_PC : redirect_tgt;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      if (enq) begin
        fetch_pc <= fetch_pc + WIDTH'(4);
        wptr     <= wptr + 1'b1;
      end
      if (deq) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (reset && enq) begin
      mem[wptr[PW-1:0]] <= '{pc: fetch_pc, instr: im_data};
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count <= (PW+1)'(DEPTH));

  a_empty_masked: assert property (@(posedge clk) disable iff (!reset)
    !out_valid |-> (pc_out == '0 && instr_out == '0 && pcadd4_out == '0));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: default instance plus a wrap instance at RESET_PC=0xFFFF_FFF8.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_req;
  logic        out_ready;

  logic [11:0] im_addr,  w_im_addr;
  logic [31:0] im_data,  w_im_data;
  logic        out_valid, w_out_valid;
  logic [31:0] instr_out, w_instr_out;
  logic [31:0] pc_out,    w_pc_out;
  logic [31:0] pcadd4_out, w_pcadd4_out;
  logic [2:0]  count,     w_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // IM word n holds 0x1000_0000 + n
  assign im_data   = 32'h1000_0000 + {20'd0, im_addr};
  assign w_im_data = 32'h1000_0000 + {20'd0, w_im_addr};

  fetch_prefetch_queue u_dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_req(exc_req), .im_addr(im_addr), .im_data(im_data), .out_valid(out_valid),
    .out_ready(out_ready), .instr_out(instr_out), .pc_out(pc_out),
    .pcadd4_out(pcadd4_out), .count(count)
  );

  fetch_prefetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_req(exc_req), .im_addr(w_im_addr), .im_data(w_im_data), .out_valid(w_out_valid),
    .out_ready(out_ready), .instr_out(w_instr_out), .pc_out(w_pc_out),
    .pcadd4_out(w_pcadd4_out), .count(w_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; exc_req = 1'b0;
    tick(); tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", instr_out); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", pc_out); end
    total++; if (pcadd4_out !== 32'h0) begin bad++; $display("FAIL reset_pcadd4 got=%h want=0", pcadd4_out); end
    total++; if (im_addr !== 12'hC00) begin bad++; $display("FAIL reset_imaddr got=%h want=c00", im_addr); end
  endtask

  task automatic test_fill();
    reset = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fill_first_valid got=%b want=1", out_valid); end
    tick(); tick(); tick();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", count); end
    total++; if (im_addr !== 12'hC04) begin bad++; $display("FAIL fill_imaddr got=%h want=c04", im_addr); end
    total++; if (instr_out !== 32'h1000_0C00) begin bad++; $display("FAIL fill_instr got=%h want=10000c00", instr_out); end
    total++; if (pc_out !== 32'h3000) begin bad++; $display("FAIL fill_pc got=%h want=3000", pc_out); end
    total++; if (pcadd4_out !== 32'h3004) begin bad++; $display("FAIL fill_pcadd4 got=%h want=3004", pcadd4_out); end
    tick();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_hold_count got=%0d want=4", count); end
    total++; if (im_addr !== 12'hC04) begin bad++; $display("FAIL full_hold_imaddr got=%h want=c04", im_addr); end
  endtask

  task automatic test_full_deq();
    logic [31:0] exp_pc;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fulldeq_count got=%0d want=4", count); end
    total++; if (pc_out !== 32'h3004) begin bad++; $display("FAIL fulldeq_pc got=%h want=3004", pc_out); end
    total++; if (im_addr !== 12'hC05) begin bad++; $display("FAIL fulldeq_imaddr got=%h want=c05", im_addr); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_pc = 32'h3004 + 32'(4 * k);
      total++; if (pc_out !== exp_pc) begin bad++; $display("FAIL drain_pc[%0d] got=%h want=%h", k, pc_out, exp_pc); end
      total++; if (count !== 3'd4) begin bad++; $display("FAIL drain_count[%0d] got=%0d want=4", k, count); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    reset = 1'b0;
    tick();
    reset = 1'b1; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      exp_pc = 32'h3000 + 32'(4 * k);
      total++; if (pc_out !== exp_pc) begin bad++; $display("FAIL stream_pc[%0d] got=%h want=%h", k, pc_out, exp_pc); end
      total++; if (instr_out !== (32'h1000_0000 + (exp_pc >> 2))) begin bad++; $display("FAIL stream_instr[%0d] got=%h want=%h", k, instr_out, 32'h1000_0000 + (exp_pc >> 2)); end
      total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d want=1", k, count); end
      tick();
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3043;
    tick();
    redirect_valid = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL redir_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b want=0", out_valid); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL redir_pc_masked got=%h want=0", pc_out); end
    total++; if (im_addr !== 12'hC10) begin bad++; $display("FAIL redir_imaddr got=%h want=c10", im_addr); end
    tick();
    total++; if (pc_out !== 32'h3040) begin bad++; $display("FAIL redir_head got=%h want=3040", pc_out); end
    total++; if (instr_out !== 32'h1000_0C10) begin bad++; $display("FAIL redir_instr got=%h want=10000c10", instr_out); end
    tick();
    total++; if (pc_out !== 32'h3044) begin bad++; $display("FAIL redir_next got=%h want=3044", pc_out); end
  endtask

  task automatic test_exc_priority();
    exc_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_3100;
    tick();
    exc_req = 1'b0; redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL exc_valid got=%b want=0", out_valid); end
    total++; if (im_addr !== 12'h060) begin bad++; $display("FAIL exc_imaddr got=%h want=060", im_addr); end
    tick();
    total++; if (pc_out !== 32'h4180) begin bad++; $display("FAIL exc_head got=%h want=4180", pc_out); end
    tick();
    total++; if (pc_out !== 32'h4184) begin bad++; $display("FAIL exc_next got=%h want=4184", pc_out); end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] exp_pcs [4];
    logic [31:0] exp_add;
    exp_pcs[0] = 32'hFFFF_FFF8; exp_pcs[1] = 32'hFFFF_FFFC;
    exp_pcs[2] = 32'h0000_0000; exp_pcs[3] = 32'h0000_0004;
    reset = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick(); tick(); tick();
    total++; if (w_count !== 3'd4) begin bad++; $display("FAIL wrap_count got=%0d want=4", w_count); end
    total++; if (w_im_addr !== 12'h002) begin bad++; $display("FAIL wrap_imaddr got=%h want=002", w_im_addr); end
    total++; if (w_instr_out !== 32'h1000_0FFE) begin bad++; $display("FAIL wrap_instr got=%h want=10000ffe", w_instr_out); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_add = exp_pcs[k] + 32'd4;
      total++; if (w_pc_out !== exp_pcs[k]) begin bad++; $display("FAIL wrap_pc[%0d] got=%h want=%h", k, w_pc_out, exp_pcs[k]); end
      total++; if (w_pcadd4_out !== exp_add) begin bad++; $display("FAIL wrap_pcadd4[%0d] got=%h want=%h", k, w_pcadd4_out, exp_add); end
      tick();
    end
    out_ready = 1'b0;
    total++; if (w_count !== 3'd4) begin bad++; $display("FAIL wrap_full got=%0d want=4", w_count); end
    reset = 1'b0;
    tick();
    total++; if (w_count !== 3'd0) begin bad++; $display("FAIL midreset_count got=%0d want=0", w_count); end
    total++; if (w_out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b want=0", w_out_valid); end
    total++; if (w_im_addr !== 12'hFFE) begin bad++; $display("FAIL midreset_imaddr got=%h want=ffe", w_im_addr); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL midreset_main_count got=%0d want=0", count); end
    total++; if (im_addr !== 12'hC00) begin bad++; $display("FAIL midreset_main_imaddr got=%h want=c00", im_addr); end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_deq();
    test_streaming();
    test_redirect();
    test_exc_priority();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Parametrised next-generation instruction fetch stage: owns the fetch PC and reads an external combinational instruction memory.
- Adds a DEPTH-entry prefetch queue with a valid/ready handshake to decode, a branch/jump redirect with flush, and an exception-vector override.
- Sits between the IM and the F/D pipeline register, replacing the plain stall-able PC register.

Parameters:
- WIDTH, 32, PC and instruction width in bits.
- DEPTH, 4, prefetch queue entries; power of two, 2..16.
- IM_AW, 12, IM word-address width; the IM index is PC[IM_AW+1:2].
- RESET_PC, 32'h0000_3000, fetch PC after reset.
- EXC_PC, 32'h0000_4180, fetch PC loaded on an exception request.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- redirect_valid  in  1  branch/jump redirect request from a later stage.
- redirect_pc  in  WIDTH  redirect target; bits [1:0] are ignored and treated as 0.
- exc_req  in  1  exception request; load EXC_PC.
- im_addr  out  IM_AW  word address to the IM; equals fetch_pc[IM_AW+1:2].
- im_data  in  WIDTH  IM read data for im_addr, same cycle (combinational).
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- instr_out  out  WIDTH  head instruction; 0 when out_valid=0.
- pc_out  out  WIDTH  head PC; 0 when out_valid=0.
- pcadd4_out  out  WIDTH  pc_out+4 modulo 2^WIDTH; 0 when out_valid=0.
- count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset=0 at a clock edge):
  - fetch_pc <= RESET_PC.
  - Read/write pointers <= 0; count <= 0.
  - out_valid, instr_out, pc_out, pcadd4_out all read 0.
  - Queue storage contents are don't-care.
  - Reset has priority over every other input, including mid-redirect and a full queue.
- Per-cycle events:
  - deq = out_valid & out_ready.
  - enq = ~flush & (count<DEPTH | deq), where flush = exc_req | redirect_valid.
- Enqueue: writes {fetch_pc, im_data} at the write pointer; then fetch_pc <= fetch_pc+4 (wraps modulo 2^WIDTH) and the write pointer advances mod DEPTH.
- Full queue:
  - With no deq, enq=0 and fetch_pc holds.
  - Full with simultaneous deq: enqueue and dequeue both occur and count stays DEPTH.
- Dequeue: the read pointer advances mod DEPTH and count decrements unless an enq occurs in the same cycle.
- Flush priority: exc_req > redirect_valid.
  - exc_req=1: fetch_pc <= EXC_PC.
  - Otherwise, if redirect_valid=1: fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00}.
  - In both cases pointers and count <= 0 next cycle.
  - No enqueue occurs in the flush cycle.
  - A deq in the flush cycle is still a legal handshake: decode consumes the current head, and the queue is then emptied.
- Latency:
  - Instruction at fetch_pc is visible at the head (out_valid=1) one cycle after its enqueue edge.
  - First instruction after reset release: out_valid=1 at the second rising edge after reset goes 1.
  - After a flush: out_valid=0 for exactly one cycle, then the target instruction is at the head.
- Queue ordering: strict FIFO in PC order. pc_out of consecutive dequeues differs by 4 unless a flush occurred between them.
- Head outputs: combinational from the read-pointer entry, masked to 0 when count=0.
- Invariants:
  - 0 <= count <= DEPTH.
  - count == (wptr - rptr) mod 2*DEPTH, using an extra pointer wrap bit.
  - No write occurs when full unless deq.

Test Plan:
- Reset/fill: hold reset=0 for 2 cycles, release with out_ready=0 and IM word n = 0x1000_0000+n -> im_addr=0xC00 after reset. After 4 enqueue cycles count=4 and fetch_pc=0x3010. Head instr=0x1000_0C00, pc_out=0x3000, pcadd4_out=0x3004. im_addr holds at 0xC04.
- Streaming: with out_ready=1 continuously -> one dequeue per cycle. pc_out sequence 0x3000, 0x3004, 0x3008… with no gaps; count stays 1.
- Full plus simultaneous deq: fill to 4, then pulse out_ready for 1 cycle -> count stays 4, head pc advances by 4, and the new tail pc is 0x3010.
- Redirect: while streaming, redirect_valid=1 with redirect_pc=0x0000_3043 -> next cycle count=0 and out_valid=0. The following cycle head pc_out=0x3040, with no entries older than 0x3040 visible.
- Exception priority: exc_req=1 and redirect_valid=1 (target 0x3100) in the same cycle -> head pc_out=0x4180. 0x3100 never appears.
- Wrap and reset mid-operation: with RESET_PC=0xFFFF_FFF8, after reset release the first 4 enqueued PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004. Asserting reset=0 while full -> next cycle count=0, out_valid=0, fetch_pc=RESET_PC.
